// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit sequencer state encoding and width helpers.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
package uart_pkg;

  // Transmit sequencer states; the encoding is shared with the register block.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_WAIT_DONE = 2'b01,
    ST_GAP       = 2'b10
  } tx_state_e;

  // Occupancy counter width: it must be able to represent a completely full FIFO.
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Inter-frame gap counter width. The counter is loaded with gap-1, so it
  // never holds more than gap-1. Keep at least one bit so the port is never empty.
  function automatic int gap_cnt_width(input int gap);
    return (gap < 2) ? 1 : $clog2(gap);
  endfunction

  // Transmitter bit counter width: start bit + payload + stop bit.
  function automatic int bit_cnt_width(input int data_bits);
    return $clog2(data_bits + 2);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with flush, occupancy level and a head word that is always readable.
// Latency: a pushed word is visible at head and in level one edge after the push.
// Backpressure: pushes while full are dropped and flagged on drop; pops while empty are ignored; flush wins over both.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  localparam int LVL_W     = level_width(FIFO_DEPTH),
  localparam int PTR_W     = $clog2(FIFO_DEPTH)
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  input  logic                 push,
  input  logic [DATA_BITS-1:0] push_data,
  input  logic                 pop,
  input  logic                 flush,
  output logic [DATA_BITS-1:0] head,
  output logic [LVL_W-1:0]     level,
  output logic                 full,
  output logic                 empty,
  output logic                 drop
);

  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [LVL_W-1:0]     r_level;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  // Fullness and emptiness come from the pre-edge level, so a push and a pop
  // in the same cycle are each judged against the level before the edge.
  assign w_full  = (r_level == LVL_W'(FIFO_DEPTH));
  assign w_empty = (r_level == '0);
  assign w_push  = push && !w_full && !flush;
  assign w_pop   = pop && !w_empty && !flush;

  assign head  = r_mem[r_rd_ptr];
  assign level = r_level;
  assign full  = w_full;
  assign empty = w_empty;
  assign drop  = push && w_full && !flush;

  // Storage array; not reset, because only entries that have been written are ever read.
  always_ff @(posedge PCLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because the depth is a power of two; flush rewinds both.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
    end
  end

  // Occupancy: a simultaneous push and pop leaves the level unchanged.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_level <= '0;
    end else if (flush) begin
      r_level <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Transmit sequencer: buffers bus bytes, launches one frame at a time, then enforces an inter-frame gap.
// Latency: a byte written into an empty FIFO launches (tx_en) two edges after its write; the next launch comes GAP_CLKS+1 edges after tx_done.
// Backpressure: writes while the FIFO is full are dropped and set sticky overflow; launches wait for enable and for the previous frame plus gap.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int GAP_CLKS   = 0,
  localparam int LVL_W     = level_width(FIFO_DEPTH),
  localparam int GAP_W     = gap_cnt_width(GAP_CLKS)
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  input  logic                 enable,
  input  logic                 flush,
  input  logic                 wr_en,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic                 ovf_clr,
  input  logic                 tx_busy,
  input  logic                 tx_done,
  output logic                 tx_en,
  output logic [DATA_BITS-1:0] tx_data,
  output logic                 fifo_empty,
  output logic                 fifo_full,
  output logic [LVL_W-1:0]     fifo_level,
  output logic                 overflow,
  output logic                 frame_sent,
  output logic                 idle
);

  tx_state_e            r_state;
  logic [GAP_W-1:0]     r_gap_cnt;
  logic                 r_tx_en;
  logic [DATA_BITS-1:0] r_tx_data;
  logic                 r_overflow;
  logic                 r_frame_sent;

  logic [DATA_BITS-1:0] w_head;
  logic                 w_fifo_empty;
  logic                 w_fifo_full;
  logic [LVL_W-1:0]     w_fifo_level;
  logic                 w_drop;
  logic                 w_launch;

  // A launch pops the head on the same edge that registers tx_en, so the level
  // already reflects the departed byte when tx_en is seen high.
  assign w_launch = (r_state == ST_IDLE) && enable && !w_fifo_empty && !flush;

  uart_sync_fifo #(
    .DATA_BITS (DATA_BITS),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .PCLK     (PCLK),
    .PRESETn  (PRESETn),
    .push     (wr_en),
    .push_data(wr_data),
    .pop      (w_launch),
    .flush    (flush),
    .head     (w_head),
    .level    (w_fifo_level),
    .full     (w_fifo_full),
    .empty    (w_fifo_empty),
    .drop     (w_drop)
  );

  // Launch / wait-for-done / gap sequencer with registered handshake outputs.
  // flush empties only the FIFO: a frame already launched still runs to tx_done and its gap.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state      <= ST_IDLE;
      r_gap_cnt    <= '0;
      r_tx_en      <= 1'b0;
      r_tx_data    <= '0;
      r_frame_sent <= 1'b0;
    end else begin
      r_tx_en      <= 1'b0;
      r_frame_sent <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_launch) begin
            r_tx_en   <= 1'b1;
            r_tx_data <= w_head;
            r_state   <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          if (tx_done) begin
            r_frame_sent <= 1'b1;
            if (GAP_CLKS == 0) begin
              r_state <= ST_IDLE;
            end else begin
              r_gap_cnt <= GAP_W'(GAP_CLKS - 1);
              r_state   <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (r_gap_cnt == '0) begin
            r_state <= ST_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt - GAP_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Sticky overflow: a dropped write wins over a clear in the same cycle.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (ovf_clr) begin
      r_overflow <= 1'b0;
    end
  end

  assign tx_en      = r_tx_en;
  assign tx_data    = r_tx_data;
  assign fifo_empty = w_fifo_empty;
  assign fifo_full  = w_fifo_full;
  assign fifo_level = w_fifo_level;
  assign overflow   = r_overflow;
  assign frame_sent = r_frame_sent;
  assign idle       = (r_state == ST_IDLE) && w_fifo_empty && !tx_busy;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler (DEPTH 16, GAP_CLKS 4).
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_uart_tx_scheduler;

  localparam int DB    = 8;
  localparam int DEPTH = 16;
  localparam int GAP   = 4;
  localparam int LW    = 5;

  logic          PCLK    = 1'b0;
  logic          PRESETn = 1'b0;
  logic          enable  = 1'b0;
  logic          flush   = 1'b0;
  logic          wr_en   = 1'b0;
  logic [DB-1:0] wr_data = '0;
  logic          ovf_clr = 1'b0;
  logic          tx_busy = 1'b0;
  logic          tx_done = 1'b0;
  logic          tx_en;
  logic [DB-1:0] tx_data;
  logic          fifo_empty;
  logic          fifo_full;
  logic [LW-1:0] fifo_level;
  logic          overflow;
  logic          frame_sent;
  logic          idle;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: queue contents, frame-in-flight flag, earliest edge a new
  // launch may happen, sticky overflow and last launched byte.
  logic [DB-1:0] mq[$];
  bit            m_busy;
  int            m_next_ok;
  bit            m_ovf;
  logic [DB-1:0] m_data;
  bit            m_en;
  bit            m_fs;
  int            n_edge   = 0;
  int            launch_n = 0;
  int            auto_dly = 0;
  int            max_lvl  = 0;
  logic [DB-1:0] sent[$];

  always #5 PCLK = ~PCLK;

  uart_tx_scheduler #(
    .DATA_BITS (DB),
    .FIFO_DEPTH(DEPTH),
    .GAP_CLKS  (GAP)
  ) dut (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .enable    (enable),
    .flush     (flush),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .ovf_clr   (ovf_clr),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done),
    .tx_en     (tx_en),
    .tx_data   (tx_data),
    .fifo_empty(fifo_empty),
    .fifo_full (fifo_full),
    .fifo_level(fifo_level),
    .overflow  (overflow),
    .frame_sent(frame_sent),
    .idle      (idle)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_busy    = 1'b0;
    m_next_ok = 0;
    m_ovf     = 1'b0;
    m_data    = '0;
    m_en      = 1'b0;
    m_fs      = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_tx_en"}, 32'(tx_en), 32'd0);
    chk({tag, "_tx_data"}, 32'(tx_data), 32'd0);
    chk({tag, "_empty"}, 32'(fifo_empty), 32'd1);
    chk({tag, "_full"}, 32'(fifo_full), 32'd0);
    chk({tag, "_level"}, 32'(fifo_level), 32'd0);
    chk({tag, "_ovf"}, 32'(overflow), 32'd0);
    chk({tag, "_fsent"}, 32'(frame_sent), 32'd0);
    chk({tag, "_idle"}, 32'(idle), 32'd1);
  endtask

  // One clock: drive at the falling edge, advance the model at the rising edge,
  // compare every output at the next falling edge.
  task automatic step(input bit en, input bit wr, input logic [DB-1:0] d,
                      input bit fl, input bit oc, input bit dn, input bit bsy);
    bit done_eff;
    bit full_pre;
    bit launch;
    bit exp_idle;
    int e;
    e        = n_edge + 1;
    done_eff = dn || (auto_dly > 0 && m_busy && (e - launch_n) == auto_dly);
    enable   = en;
    wr_en    = wr;
    wr_data  = d;
    flush    = fl;
    ovf_clr  = oc;
    tx_done  = done_eff;
    tx_busy  = bsy;
    @(posedge PCLK);
    full_pre = (mq.size() == DEPTH);
    launch   = !m_busy && (e >= m_next_ok) && en && (mq.size() > 0) && !fl;
    m_fs     = m_busy && done_eff;
    m_en     = launch;
    if (m_fs) begin
      m_busy    = 1'b0;
      m_next_ok = e + GAP + 1;
    end
    if (launch) begin
      m_data   = mq.pop_front();
      m_busy   = 1'b1;
      launch_n = e;
    end
    if (fl) mq.delete();
    else if (wr && !full_pre) mq.push_back(d);
    if (wr && full_pre && !fl) m_ovf = 1'b1;
    else if (oc) m_ovf = 1'b0;
    n_edge   = e;
    exp_idle = !m_busy && (e + 1 >= m_next_ok) && (mq.size() == 0) && !bsy;
    @(negedge PCLK);
    chk("tx_en", 32'(tx_en), 32'(m_en));
    chk("tx_data", 32'(tx_data), 32'(m_data));
    chk("fifo_level", 32'(fifo_level), 32'(mq.size()));
    chk("fifo_empty", 32'(fifo_empty), 32'(mq.size() == 0));
    chk("fifo_full", 32'(fifo_full), 32'(mq.size() == DEPTH));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("frame_sent", 32'(frame_sent), 32'(m_fs));
    chk("idle", 32'(idle), 32'(exp_idle));
    if (tx_en === 1'b1) sent.push_back(tx_data);
    if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
  endtask

  task automatic run(input int k, input bit en);
    for (int i = 0; i < k; i++) step(en, 1'b0, '0, 1'b0, 1'b0, 1'b0, m_busy);
  endtask

  task automatic async_reset(input string tag);
    #2;
    tx_busy = 1'b0;
    tx_done = 1'b0;
    wr_en   = 1'b0;
    PRESETn = 1'b0;
    #1;
    check_reset_vals(tag);
    model_reset();
    @(negedge PCLK);
    PRESETn = 1'b1;
  endtask

  initial begin
    model_reset();
    // Reset state
    #12;
    check_reset_vals("reset");
    @(negedge PCLK);
    PRESETn = 1'b1;

    // Single byte: launch two edges after write, long frame, frame_sent, idle after gap
    step(1, 1, 8'h55, 0, 0, 0, 0);
    run(100, 1);
    step(1, 0, '0, 0, 0, 1, 1);
    run(8, 1);
    chk("single_byte", 32'(sent.size() == 1 ? sent[0] : 8'h00), 32'h55);

    // Burst with gap: strict order, gap timing enforced by the model
    sent.delete();
    auto_dly = 3;
    step(1, 1, 8'h11, 0, 0, 0, m_busy);
    step(1, 1, 8'h22, 0, 0, 0, m_busy);
    step(1, 1, 8'h33, 0, 0, 0, m_busy);
    run(40, 1);
    chk("burst_count", 32'(sent.size()), 32'd3);
    if (sent.size() == 3) begin
      chk("burst_b0", 32'(sent[0]), 32'h11);
      chk("burst_b1", 32'(sent[1]), 32'h22);
      chk("burst_b2", 32'(sent[2]), 32'h33);
    end

    // Overflow: 17 writes with enable low; clear in the overflowing cycle is overridden
    auto_dly = 0;
    for (int i = 0; i < 16; i++) step(0, 1, 8'(8'hA0 + i), 0, 0, 0, 0);
    step(0, 1, 8'hEE, 0, 1, 0, 0);
    chk("ovf_level16", 32'(fifo_level), 32'd16);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    step(0, 0, '0, 0, 1, 0, 0);
    chk("ovf_cleared", 32'(overflow), 32'd0);
    sent.delete();
    auto_dly = 2;
    run(16 * 8 + 10, 1);
    chk("ovf_drain_count", 32'(sent.size()), 32'd16);
    for (int i = 0; i < sent.size() && i < 16; i++) chk("ovf_drain_byte", 32'(sent[i]), 32'(8'hA0 + i));

    // Wrap-around: 40 incrementing bytes through the FIFO
    sent.delete();
    max_lvl  = 0;
    auto_dly = 1;
    for (int i = 0; i < 40; i++) begin
      step(1, 1, 8'(i), 0, 0, 0, m_busy);
      run(5, 1);
    end
    run(20, 1);
    chk("wrap_count", 32'(sent.size()), 32'd40);
    for (int i = 0; i < sent.size() && i < 40; i++) chk("wrap_byte", 32'(sent[i]), 32'(i));
    chk("wrap_max_level_ok", 32'(max_lvl <= DEPTH), 32'd1);

    // Flush mid-frame: in-flight frame completes, nothing further launched
    sent.delete();
    auto_dly = 0;
    step(1, 1, 8'h61, 0, 0, 0, m_busy);
    step(1, 1, 8'h62, 0, 0, 0, m_busy);
    step(1, 1, 8'h63, 0, 0, 0, m_busy);
    step(1, 0, '0, 1, 0, 0, m_busy);
    run(4, 1);
    step(1, 0, '0, 0, 0, 1, 1);
    run(20, 1);
    chk("flush_launches", 32'(sent.size()), 32'd1);

    // Disable during WAIT_DONE: no relaunch after tx_done until re-enabled
    sent.delete();
    step(1, 1, 8'h71, 0, 0, 0, m_busy);
    step(1, 1, 8'h72, 0, 0, 0, m_busy);
    run(2, 1);
    run(3, 0);
    step(0, 0, '0, 0, 0, 1, 1);
    run(20, 0);
    chk("disable_launches", 32'(sent.size()), 32'd1);
    auto_dly = 2;
    run(20, 1);
    chk("reenable_launches", 32'(sent.size()), 32'd2);

    // Asynchronous reset mid-frame with bytes queued and overflow set
    auto_dly = 0;
    for (int i = 0; i < 18; i++) step(1, 1, 8'(8'hC0 + i), 0, 0, 0, m_busy);
    run(3, 1);
    async_reset("midframe_reset");

    // Randomised traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 8) != 0, $urandom % 2, 8'($urandom), ($urandom % 64) == 0,
           ($urandom % 16) == 0, ($urandom % 6) == 0, $urandom % 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
